// File: rtl/serial_add_seq_if.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | serial_add_seq_if : start/done handshake bundle for the         |
// |                     bit-serial adder sequencer.                 |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
interface serial_add_seq_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] in_A;
    logic [WIDTH-1:0] in_B;
    logic             Cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] out_sum;
    logic             Cout;

    modport master (
        output start, in_A, in_B, Cin,
        input  busy, done, out_sum, Cout
    );

    modport slave (
        input  start, in_A, in_B, Cin,
        output busy, done, out_sum, Cout
    );
endinterface
`default_nettype wire

// File: rtl/serial_add_seq.sv
`default_nettype none
// +-----------------------------------------------------------------+
// | serial_add_seq : one full-adder cell plus carry flop producing  |
// |                  a WIDTH-bit sum LSB first, one bit per cycle.  |
// | Rev 1.0                                                         |
// +-----------------------------------------------------------------+
module serial_add_seq #(
    parameter int WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    serial_add_seq_if.slave bus
);

    localparam int               CNT_W  = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nx;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_s_sr;
    logic [WIDTH-1:0] w_s_nx;
    logic [WIDTH-1:0] r_out_sum;
    logic [CNT_W-1:0] r_cnt;
    logic             r_c_q;
    logic             r_cout;
    logic             r_busy;
    logic             r_done;
    logic             w_sum;
    logic             w_carry;
    logic             w_last;

    assign w_sum   = r_a_sr[0] ^ r_b_sr[0] ^ r_c_q;
    assign w_carry = (r_c_q & (r_a_sr[0] ^ r_b_sr[0])) | (r_a_sr[0] & r_b_sr[0]);
    assign w_last  = (r_cnt == C_LAST);

    // New sum bit enters at the MSB so the LSB-first stream lands in place.
    generate
        if (WIDTH == 1) begin : g_s_one
            assign w_s_nx = w_sum;
        end else begin : g_s_multi
            assign w_s_nx = {w_sum, r_s_sr[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (bus.start) w_state_nx = S_RUN;
            S_RUN:   if (w_last)    w_state_nx = S_DONE;
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // Status flags are flopped from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nx != S_IDLE);
            r_done <= (w_state_nx == S_DONE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_a_sr    <= '0;
            r_b_sr    <= '0;
            r_s_sr    <= '0;
            r_c_q     <= 1'b0;
            r_cnt     <= '0;
            r_out_sum <= '0;
            r_cout    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a_sr <= bus.in_A;
                        r_b_sr <= bus.in_B;
                        r_c_q  <= bus.Cin;
                        r_cnt  <= '0;
                        r_s_sr <= '0;
                    end
                end
                S_RUN: begin
                    r_s_sr <= w_s_nx;
                    r_a_sr <= r_a_sr >> 1;
                    r_b_sr <= r_b_sr >> 1;
                    r_c_q  <= w_carry;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_out_sum <= w_s_nx;
                        r_cout    <= w_carry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.out_sum = r_out_sum;
    assign bus.Cout    = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_seq.sv
`default_nettype none
// Bench for serial_add_seq: directed checks on an 8-bit instance plus
// randomized traffic on 1/8/16-bit instances against a timing/arithmetic model.
module tb_serial_add_seq;

    localparam int RAND_CYC = 40000;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic       dir_done = 1'b0;
    logic       d_start  = 1'b0;
    logic [7:0] d_a      = 8'h00;
    logic [7:0] d_b      = 8'h00;
    logic       d_cin    = 1'b0;

    logic       t_busy;
    logic       t_done;
    logic [7:0] t_sum;
    logic       t_cout;
    logic [2:0] fin;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_w
        localparam int W = (gi == 0) ? 1 : (gi == 1) ? 8 : 16;

        serial_add_seq_if #(.WIDTH(W)) bus ();
        serial_add_seq #(.WIDTH(W)) dut (
            .clk   (clk),
            .rst_n (rst_n),
            .bus   (bus)
        );

        logic         r_start = 1'b0;
        logic [W-1:0] r_a     = '0;
        logic [W-1:0] r_b     = '0;
        logic         r_cin   = 1'b0;
        logic         r_fin   = 1'b0;

        assign bus.start = dir_done ? r_start : ((gi == 1) && d_start);
        assign bus.in_A  = dir_done ? r_a     : W'(d_a);
        assign bus.in_B  = dir_done ? r_b     : W'(d_b);
        assign bus.Cin   = dir_done ? r_cin   : d_cin;
        assign fin[gi]   = r_fin;

        if (gi == 1) begin : g_tap
            assign t_busy = bus.busy;
            assign t_done = bus.done;
            assign t_sum  = bus.out_sum;
            assign t_cout = bus.Cout;
        end

        initial begin
            wait (dir_done);
            repeat (RAND_CYC) begin
                @(negedge clk);
                r_start = ($urandom_range(0, 3) != 0);
                r_a     = W'($urandom);
                r_b     = W'($urandom);
                r_cin   = 1'($urandom);
            end
            @(negedge clk);
            r_start = 1'b0;
            r_fin   = 1'b1;
        end

        // Model: an accepted request occupies edges acc..acc+W+1; done shows
        // after edge acc+W, where the exact sum becomes the visible result.
        initial begin
            int       e;
            int       acc;
            bit       run;
            bit       x_busy;
            bit       x_done;
            logic [W:0] pend;
            logic [W:0] res;
            e = 0; acc = 0; run = 1'b0; res = '0; pend = '0;
            forever begin
                @(posedge clk);
                e++;
                if (!rst_n) begin
                    run = 1'b0;
                    res = '0;
                end else if (run) begin
                    if (e == acc + W + 1) run = 1'b0;
                end else if (bus.start) begin
                    run  = 1'b1;
                    acc  = e;
                    pend = (W+1)'(bus.in_A) + (W+1)'(bus.in_B) + (W+1)'(bus.Cin);
                end
                x_busy = run;
                x_done = run && (e == acc + W);
                if (x_done) res = pend;
                #1;
                tests++;
                if (bus.busy !== x_busy || bus.done !== x_done || {bus.Cout, bus.out_sum} !== res) begin
                    fails++;
                    $display("FAIL model_w%0d edge %0d: busy=%b done=%b res=%h, required busy=%b done=%b res=%h",
                             W, e, bus.busy, bus.done, {bus.Cout, bus.out_sum}, x_busy, x_done, res);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // Called at a negedge with the 8-bit instance idle; returns at a negedge.
    task automatic run_op(input string nm, input logic [7:0] a, input logic [7:0] b,
                          input logic c, input logic [8:0] prev, input logic [8:0] expv);
        int lat;
        bit held;
        chk({nm, " idle before"}, 32'(t_busy), 32'd0);
        d_start = 1'b1; d_a = a; d_b = b; d_cin = c;
        @(negedge clk);
        d_start = 1'b0;
        chk({nm, " busy after accept"}, 32'(t_busy), 32'd1);
        lat  = 0;
        held = 1'b1;
        while (t_done !== 1'b1 && lat < 40) begin
            if ({t_cout, t_sum} !== prev) held = 1'b0;
            @(negedge clk);
            lat++;
            d_a = 8'($urandom); d_b = 8'($urandom); d_cin = 1'($urandom);
        end
        // Accepting edge k, done visible after edge k+8 (cycle k+9).
        chk({nm, " done latency"}, 32'(lat), 32'd8);
        chk({nm, " result held during run"}, 32'(held), 32'd1);
        chk({nm, " result"}, 32'({t_cout, t_sum}), 32'(expv));
        @(negedge clk);
        chk({nm, " single done pulse"}, 32'({t_busy, t_done}), 32'd0);
    endtask

    initial begin
        int         r1;
        int         r2;
        int         nd;
        bit         pb;
        logic [8:0] sec;

        repeat (3) @(negedge clk);
        chk("reset state", 32'({t_busy, t_done, t_cout, t_sum}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("add_5a_3c", 8'h5A, 8'h3C, 1'b0, 9'h000, 9'h096);
        run_op("ripple_ff_01", 8'hFF, 8'h01, 1'b0, 9'h096, 9'h100);
        run_op("ripple_ff_00_cin", 8'hFF, 8'h00, 1'b1, 9'h100, 9'h100);

        // start held high with operands scrambled every cycle
        d_start = 1'b1; d_a = 8'h11; d_b = 8'h22; d_cin = 1'b1;
        @(negedge clk);
        pb = 1'b0; r1 = -1; r2 = -1; nd = 0; sec = '0;
        for (int n = 0; n < 20; n++) begin
            if (t_busy && !pb) begin
                if (r1 < 0) r1 = n;
                else if (r2 < 0) r2 = n;
            end
            pb = t_busy;
            if (t_done) begin
                nd++;
                if (n == 8) chk("held_start first result", 32'({t_cout, t_sum}), 32'h034);
                else        chk("held_start second result", 32'({t_cout, t_sum}), 32'(sec));
            end
            d_a = 8'($urandom); d_b = 8'($urandom); d_cin = 1'($urandom);
            if (n == 9)  sec = 9'(d_a) + 9'(d_b) + 9'(d_cin);
            if (n == 19) d_start = 1'b0;
            @(negedge clk);
        end
        chk("held_start first accept", 32'(r1), 32'd0);
        chk("held_start accept spacing", 32'(r2 - r1), 32'd10);
        chk("held_start done count", 32'(nd), 32'd2);

        // abort in cycle k+4, with start asserted on the reset edge
        d_start = 1'b1; d_a = 8'h12; d_b = 8'h34; d_cin = 1'b0;
        @(negedge clk);
        d_start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n   = 1'b0;
        d_start = 1'b1;
        @(negedge clk);
        chk("abort outputs cleared", 32'({t_busy, t_done, t_cout, t_sum}), 32'd0);
        d_start = 1'b0;
        rst_n   = 1'b1;
        nd = 0;
        repeat (12) begin
            @(negedge clk);
            if (t_done) nd++;
        end
        chk("abort no done pulse", 32'(nd), 32'd0);
        run_op("post_abort", 8'h80, 8'h80, 1'b1, 9'h000, 9'h101);

        dir_done = 1'b1;
        wait (fin == 3'b111);
        repeat (30) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #(10_000_000);
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1);
    end

endmodule
`default_nettype wire
